// File: rtl/tb_phase_sequencer_if.sv
// Bundles the control/status signals between the test bench and the phase
// sequencer. The master side is the bench. The slave side is the sequencer.
interface tb_phase_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             i__start;
    logic             i__abort;
    logic [CNT_W-1:0] i__gen_cycles;
    logic [CNT_W-1:0] i__drain_cycles;
    logic [CNT_W-1:0] i__num_iters;
    logic             i__stop_on_empty;
    logic             i__pifo_empty;
    logic             o__generate_phase;
    logic             o__drain_phase;
    logic [CNT_W-1:0] o__phase_count;
    logic [CNT_W-1:0] o__iteration;
    logic             o__busy;
    logic             o__done;
    logic             o__aborted;

    modport master (
        output i__start, i__abort, i__gen_cycles, i__drain_cycles, i__num_iters,
               i__stop_on_empty, i__pifo_empty,
        input  o__generate_phase, o__drain_phase, o__phase_count, o__iteration,
               o__busy, o__done, o__aborted
    );

    modport slave (
        input  i__start, i__abort, i__gen_cycles, i__drain_cycles, i__num_iters,
               i__stop_on_empty, i__pifo_empty,
        output o__generate_phase, o__drain_phase, o__phase_count, o__iteration,
               o__busy, o__done, o__aborted
    );
endinterface

// File: rtl/tb_phase_sequencer.sv
// Phase sequencer: alternates GENERATE and DRAIN windows for a latched number
// of iterations. It drives the traffic generator and the PIFO dequeue enable.
// Config is captured at start, so the bench may reprogram it mid-run.
module tb_phase_sequencer #(
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 reset,
    tb_phase_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] iter_q,      iter_d;
    logic             aborted_q,   aborted_d;
    logic [CNT_W-1:0] gen_len_q,   gen_len_d;
    logic [CNT_W-1:0] drain_len_q, drain_len_d;
    logic [CNT_W-1:0] num_iters_q, num_iters_d;
    logic             stop_q,      stop_d;
    logic             gen_phase_q, gen_phase_d;
    logic             drn_phase_q, drn_phase_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             drain_end_s;

    // A DRAIN window closes on its length, or early on PIFO empty after at least two cycles.
    always_comb begin
        drain_end_s = (cnt_q == (drain_len_q - CNT_ONE)) ||
                      (stop_q && bus.i__pifo_empty && (cnt_q >= CNT_ONE));
    end

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        iter_d      = iter_q;
        aborted_d   = aborted_q;
        gen_len_d   = gen_len_q;
        drain_len_d = drain_len_q;
        num_iters_d = num_iters_q;
        stop_d      = stop_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A start here wins over a simultaneous abort, which idle states ignore.
                if (bus.i__start) begin
                    gen_len_d   = (bus.i__gen_cycles == CNT_ZERO) ? CNT_ONE : bus.i__gen_cycles;
                    drain_len_d = (bus.i__drain_cycles == CNT_ZERO) ? CNT_ONE : bus.i__drain_cycles;
                    num_iters_d = bus.i__num_iters;
                    stop_d      = bus.i__stop_on_empty;
                    cnt_d       = CNT_ZERO;
                    iter_d      = CNT_ZERO;
                    aborted_d   = 1'b0;
                    if (bus.i__num_iters == CNT_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GEN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_GEN: begin
                if (bus.i__abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                end else if (cnt_q == (gen_len_q - CNT_ONE)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (bus.i__abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                end else if (drain_end_s) begin
                    cnt_d = CNT_ZERO;
                    if (iter_q == (num_iters_q - CNT_ONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GEN;
                        iter_d  = iter_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        gen_phase_d = (state_d == ST_GEN);
        drn_phase_d = (state_d == ST_DRAIN);
        busy_d      = (state_d == ST_GEN) || (state_d == ST_DRAIN);
        done_d      = (state_d == ST_DONE);
    end

    // State, latched config, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            iter_q      <= CNT_ZERO;
            aborted_q   <= 1'b0;
            gen_len_q   <= CNT_ZERO;
            drain_len_q <= CNT_ZERO;
            num_iters_q <= CNT_ZERO;
            stop_q      <= 1'b0;
            gen_phase_q <= 1'b0;
            drn_phase_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            iter_q      <= iter_d;
            aborted_q   <= aborted_d;
            gen_len_q   <= gen_len_d;
            drain_len_q <= drain_len_d;
            num_iters_q <= num_iters_d;
            stop_q      <= stop_d;
            gen_phase_q <= gen_phase_d;
            drn_phase_q <= drn_phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.o__generate_phase = gen_phase_q;
    assign bus.o__drain_phase    = drn_phase_q;
    assign bus.o__phase_count    = cnt_q;
    assign bus.o__iteration      = iter_q;
    assign bus.o__busy           = busy_q;
    assign bus.o__done           = done_q;
    assign bus.o__aborted        = aborted_q;
endmodule

// File: tb/tb_tb_phase_sequencer.sv
// Directed test bench for the phase sequencer. Expected values are hand-computed.
module tb_tb_phase_sequencer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    tb_phase_sequencer_if #(.CNT_W(32)) bus();

    tb_phase_sequencer #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gen"},   {31'd0, bus.o__generate_phase}, 32'd0);
        chk({tag, "_drain"}, {31'd0, bus.o__drain_phase},    32'd0);
        chk({tag, "_cnt"},   bus.o__phase_count,             32'd0);
        chk({tag, "_iter"},  bus.o__iteration,               32'd0);
        chk({tag, "_busy"},  {31'd0, bus.o__busy},           32'd0);
        chk({tag, "_done"},  {31'd0, bus.o__done},           32'd0);
        chk({tag, "_abort"}, {31'd0, bus.o__aborted},        32'd0);
    endtask

    // Runs from an already-raised start until done; counts phase cycles.
    // With pulse set, start is re-pulsed with gen_cycles=9 on the first DRAIN cycle.
    task automatic run(input bit pulse, output int gc, output int dc, output int ov,
                       output int cyc, output bit fin);
        bit pulsed;
        pulsed = 1'b0;
        gc = 0; dc = 0; ov = 0; cyc = 0; fin = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            bus.i__start = 1'b0;
            if (bus.o__done) begin
                fin = 1'b1;
                cyc = i;
                break;
            end
            gc += int'(bus.o__generate_phase);
            dc += int'(bus.o__drain_phase);
            ov += int'(bus.o__generate_phase & bus.o__drain_phase);
            if (pulse && bus.o__drain_phase && !pulsed) begin
                bus.i__start       = 1'b1;
                bus.i__gen_cycles  = 32'd9;
                pulsed             = 1'b1;
            end
        end
    endtask

    task automatic setup(input int g, input int d, input int n, input bit s, input bit e);
        bus.i__gen_cycles    = g;
        bus.i__drain_cycles  = d;
        bus.i__num_iters     = n;
        bus.i__stop_on_empty = s;
        bus.i__pifo_empty    = e;
        bus.i__start         = 1'b1;
    endtask

    initial begin
        int gc, dc, ov, cyc;
        bit fin;
        logic exp_g, exp_d, exp_done;
        tests = 0;
        fails = 0;
        bus.i__start = 1'b0;
        bus.i__abort = 1'b0;
        bus.i__gen_cycles = 32'd0;
        bus.i__drain_cycles = 32'd0;
        bus.i__num_iters = 32'd0;
        bus.i__stop_on_empty = 1'b0;
        bus.i__pifo_empty = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b1;
        tick();
        chk_idle("post_reset");

        // Reset in the middle of a GEN window.
        setup(10, 2, 1, 1'b0, 1'b0);
        tick();
        bus.i__start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midgen_cnt", bus.o__phase_count, 32'd4);
        chk("midgen_gen", {31'd0, bus.o__generate_phase}, 32'd1);
        reset = 1'b0;
        tick();
        chk_idle("midgen_rst");
        reset = 1'b1;
        tick();
        chk("midgen_idle_busy", {31'd0, bus.o__busy}, 32'd0);

        // gen=3 drain=2 iters=2: cycle-by-cycle window check.
        setup(3, 2, 2, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            bus.i__start = 1'b0;
            exp_g    = ((k >= 1) && (k <= 3)) || ((k >= 6) && (k <= 8));
            exp_d    = ((k >= 4) && (k <= 5)) || ((k >= 9) && (k <= 10));
            exp_done = (k >= 11);
            chk($sformatf("seq_gen_T%0d", k),   {31'd0, bus.o__generate_phase}, {31'd0, exp_g});
            chk($sformatf("seq_drain_T%0d", k), {31'd0, bus.o__drain_phase},    {31'd0, exp_d});
            chk($sformatf("seq_done_T%0d", k),  {31'd0, bus.o__done},           {31'd0, exp_done});
            if (k == 3)  chk("seq_cnt_T3", bus.o__phase_count, 32'd2);
            if (k == 6)  chk("seq_iter_T6", bus.o__iteration, 32'd1);
            if (k == 11) chk("seq_iter_T11", bus.o__iteration, 32'd1);
        end

        // Early drain exit on PIFO empty: exactly 2 drain cycles.
        setup(2, 8, 1, 1'b1, 1'b1);
        run(1'b0, gc, dc, ov, cyc, fin);
        chk("empty_fin", {31'd0, fin}, 32'd1);
        chk("empty_drain", dc, 32'd2);
        chk("empty_cyc", cyc, 32'd5);

        // Same but PIFO never empty: full 8 drain cycles.
        setup(2, 8, 1, 1'b1, 1'b0);
        run(1'b0, gc, dc, ov, cyc, fin);
        chk("full_fin", {31'd0, fin}, 32'd1);
        chk("full_drain", dc, 32'd8);
        chk("full_cyc", cyc, 32'd11);

        // Zero iterations: done next cycle, no GEN.
        setup(5, 5, 0, 1'b0, 1'b0);
        run(1'b0, gc, dc, ov, cyc, fin);
        chk("zero_it_cyc", cyc, 32'd1);
        chk("zero_it_gen", gc, 32'd0);
        chk("zero_it_iter", bus.o__iteration, 32'd0);

        // Zero lengths clamp to one cycle each.
        setup(0, 0, 1, 1'b0, 1'b0);
        run(1'b0, gc, dc, ov, cyc, fin);
        chk("clamp_gen", gc, 32'd1);
        chk("clamp_drain", dc, 32'd1);
        chk("clamp_cyc", cyc, 32'd3);

        // Abort at GEN count 5.
        setup(10, 2, 3, 1'b0, 1'b0);
        tick();
        bus.i__start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_pre_cnt", bus.o__phase_count, 32'd5);
        bus.i__abort = 1'b1;
        tick();
        chk("abort_done", {31'd0, bus.o__done}, 32'd1);
        chk("abort_flag", {31'd0, bus.o__aborted}, 32'd1);
        chk("abort_gen", {31'd0, bus.o__generate_phase}, 32'd0);
        chk("abort_busy", {31'd0, bus.o__busy}, 32'd0);
        chk("abort_iter", bus.o__iteration, 32'd0);
        // Abort still high plus start in DONE: start wins.
        bus.i__start = 1'b1;
        tick();
        chk("restart_flag", {31'd0, bus.o__aborted}, 32'd0);
        chk("restart_gen", {31'd0, bus.o__generate_phase}, 32'd1);
        chk("restart_done", {31'd0, bus.o__done}, 32'd0);
        chk("restart_cnt", bus.o__phase_count, 32'd0);
        bus.i__abort = 1'b0;
        run(1'b0, gc, dc, ov, cyc, fin);
        chk("restart_fin", {31'd0, fin}, 32'd1);
        chk("restart_iter", bus.o__iteration, 32'd2);
        chk("restart_noabort", {31'd0, bus.o__aborted}, 32'd0);

        // Start re-pulsed in DRAIN with new gen_cycles is ignored.
        setup(3, 4, 2, 1'b0, 1'b0);
        run(1'b1, gc, dc, ov, cyc, fin);
        chk("busy_start_fin", {31'd0, fin}, 32'd1);
        chk("busy_start_gen", gc, 32'd6);
        chk("busy_start_drain", dc, 32'd8);
        chk("busy_start_cyc", cyc, 32'd15);
        chk("busy_start_overlap", ov, 32'd0);
        chk("busy_start_iter", bus.o__iteration, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
